// File: rtl/exec_unit_param.sv
// Parametrised execution unit: single-cycle ALU ops plus iterative shift-add MUL
// and restoring DIV/REM sharing one datapath, with valid/ready on both sides.
module exec_unit_param #(
  parameter int WIDTH       = 8,
  parameter bit SIGNED_MODE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 err,
  output logic                 busy
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_REM = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic [3:0] op;
    logic       neg_q;   // negate product / quotient at the end
    logic       neg_r;   // negate remainder at the end
  } req_t;

  state_e               r_state, w_state_nxt;
  req_t                 r_req;
  logic [WIDTH-1:0]     r_hi, r_lo, r_bmag;
  logic [SW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_zero, r_err;

  logic                 w_accept, w_iter;
  logic [WIDTH-1:0]     w_amag, w_bmag, w_shl, w_shr;
  logic [WIDTH:0]       w_add, w_sub;
  logic [2*WIDTH-1:0]   w_imm;
  logic                 w_imm_err;
  logic [WIDTH:0]       w_msum, w_dtrial;
  logic [WIDTH-1:0]     w_hi_nxt, w_lo_nxt, w_quot, w_rem;
  logic [2*WIDTH-1:0]   w_prod, w_fin;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return (SIGNED_MODE && v[WIDTH-1]) ? WIDTH'(-v) : v;
  endfunction

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign err       = r_err;

  // Divide by zero short-circuits to DONE; MUL iterates regardless of B.
  assign w_iter = (opcode == OP_MUL) |
                  (((opcode == OP_DIV) | (opcode == OP_REM)) & (B != '0));

  assign w_amag = mag(A);
  assign w_bmag = mag(B);
  assign w_add  = {1'b0, A} + {1'b0, B};
  assign w_sub  = {1'b0, A} - {1'b0, B};
  assign w_shl  = A << B[SW-1:0];
  assign w_shr  = A >> B[SW-1:0];

  always_comb begin
    w_imm     = '0;
    w_imm_err = 1'b0;
    case (opcode)
      OP_ADD: w_imm = {{(WIDTH-1){1'b0}}, w_add};
      OP_SUB: w_imm = {{(WIDTH-1){1'b0}}, w_sub};
      OP_AND: w_imm = {{WIDTH{1'b0}}, A & B};
      OP_OR:  w_imm = {{WIDTH{1'b0}}, A | B};
      OP_XOR: w_imm = {{WIDTH{1'b0}}, A ^ B};
      OP_NOT: w_imm = {{WIDTH{1'b0}}, ~A};
      OP_SHL: w_imm = {{WIDTH{1'b0}}, w_shl};
      OP_SHR: w_imm = {{WIDTH{1'b0}}, w_shr};
      OP_MUL: w_imm = '0;
      OP_DIV: begin
        w_imm     = {A, {WIDTH{1'b1}}};
        w_imm_err = 1'b1;
      end
      OP_REM: begin
        w_imm     = {{WIDTH{1'b0}}, A};
        w_imm_err = 1'b1;
      end
      default: w_imm_err = 1'b1;
    endcase
  end

  // One iteration step: r_lo holds the multiplier (MUL) or the dividend
  // being shifted out while quotient bits shift in (DIV/REM).
  always_comb begin
    w_msum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_bmag : {WIDTH{1'b0}})};
    w_dtrial = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_bmag};
    if (r_req.op == OP_MUL) begin
      w_hi_nxt = w_msum[WIDTH:1];
      w_lo_nxt = {w_msum[0], r_lo[WIDTH-1:1]};
    end else if (!w_dtrial[WIDTH]) begin
      w_hi_nxt = w_dtrial[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_nxt = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
      w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  assign w_prod = {w_hi_nxt, w_lo_nxt};
  assign w_quot = r_req.neg_q ? WIDTH'(-w_lo_nxt) : w_lo_nxt;
  assign w_rem  = r_req.neg_r ? WIDTH'(-w_hi_nxt) : w_hi_nxt;

  always_comb begin
    w_fin = '0;
    case (r_req.op)
      OP_MUL:  w_fin = r_req.neg_q ? (2*WIDTH)'(-w_prod) : w_prod;
      OP_DIV:  w_fin = {w_rem, w_quot};
      default: w_fin = {{WIDTH{1'b0}}, w_rem};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_iter ? S_RUN : S_DONE;
      S_RUN:  if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_accept)       w_state_nxt = w_iter ? S_RUN : S_DONE;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_bmag   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_req.op    <= opcode;
      r_req.neg_q <= SIGNED_MODE && (A[WIDTH-1] ^ B[WIDTH-1]);
      r_req.neg_r <= SIGNED_MODE && A[WIDTH-1];
      r_hi        <= '0;
      r_lo        <= w_amag;
      r_bmag      <= w_bmag;
      r_cnt       <= SW'(WIDTH-1);
      if (!w_iter) begin
        r_result <= w_imm;
        r_zero   <= (w_imm == '0);
        r_err    <= w_imm_err;
      end
    end else if (r_state == S_RUN) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt - SW'(1);
      if (r_cnt == '0) begin
        r_result <= w_fin;
        r_zero   <= (w_fin == '0);
        r_err    <= 1'b0;
      end
    end
  end

endmodule
